// File: rtl/change_dispenser_pkg.sv
// Shared coin-interface definitions: legal coin values and the dispenser FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package change_dispenser_pkg;

  // Coin values as seen on the coin bus; the coin validator checks against the same constants.
  typedef logic [3:0] coin_t;

  localparam coin_t COIN_NONE = 4'd0;
  localparam coin_t COIN_1    = 4'd1;
  localparam coin_t COIN_5    = 4'd5;
  localparam coin_t COIN_10   = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER,
    FINISH
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller / coin-eject mechanism and the change dispenser.
// Latency: n/a (wires only).
// Backpressure: coin_valid/coin_ack handshake; the dispenser holds a coin until it is acked.
// Ports: start/change_amount/refill/ready (controller request), coin_out/coin_valid/coin_ack (eject),
//        done/error/remaining (transaction status).
interface change_dispenser_if
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8
);
  logic             start;
  logic [AMT_W-1:0] change_amount;
  logic             refill;
  logic             ready;
  coin_t            coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] remaining;

  // Controller / eject side.
  modport master (
    output start, change_amount, refill, coin_ack,
    input  ready, coin_out, coin_valid, done, error, remaining
  );

  // Dispenser side.
  modport slave (
    input  start, change_amount, refill, coin_ack,
    output ready, coin_out, coin_valid, done, error, remaining
  );
endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin choice: largest coin that fits in the amount owed and is still in stock.
// Latency: combinational.
// Backpressure: none.
// Ports: remaining (NIS owed), has_10/has_5/has_1 (stock non-zero), coin (COIN_NONE if nothing fits).
module change_dispenser_coin_selector
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic             has_10,
  input  logic             has_5,
  input  logic             has_1,
  output coin_t            coin
);

  always_comb begin
    coin = COIN_NONE;
    if (remaining >= AMT_W'(10) && has_10) begin
      coin = COIN_10;
    end else if (remaining >= AMT_W'(5) && has_5) begin
      coin = COIN_5;
    end else if (remaining >= AMT_W'(1) && has_1) begin
      coin = COIN_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as a stream of 10/5/1 NIS coins, largest first, from per-denomination stock.
// Latency: start -> first coin_valid 2 cycles; one SELECT cycle between coins; done 1 cycle after last decision.
// Backpressure: a coin stays on coin_out with coin_valid high until coin_ack; no timeout.
// Ports: clk, rst (sync, active-high); bus = change_dispenser_if.slave (request, coin handshake, status).
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 6,
  parameter int INIT_STOCK = 20
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  localparam logic [CNT_W-1:0] STOCK_FULL = CNT_W'(INIT_STOCK);

  state_t           state;
  logic [CNT_W-1:0] stk10, stk5, stk1;
  logic [AMT_W-1:0] remaining_q;
  coin_t            coin_q;
  coin_t            sel_coin;
  logic             ready_q, valid_q, done_q, error_q;

  change_dispenser_coin_selector #(.AMT_W(AMT_W)) u_sel (
    .remaining (remaining_q),
    .has_10    (stk10 != '0),
    .has_5     (stk5 != '0),
    .has_1     (stk1 != '0),
    .coin      (sel_coin)
  );

  assign bus.ready      = ready_q;
  assign bus.coin_out   = coin_q;
  assign bus.coin_valid = valid_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.remaining  = remaining_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      coin_q      <= COIN_NONE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      remaining_q <= '0;
      stk10       <= STOCK_FULL;
      stk5        <= STOCK_FULL;
      stk1        <= STOCK_FULL;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Refill and start may land together; the new transaction sees full stock.
          if (bus.refill) begin
            stk10 <= STOCK_FULL;
            stk5  <= STOCK_FULL;
            stk1  <= STOCK_FULL;
          end
          if (bus.start) begin
            remaining_q <= bus.change_amount;
            error_q     <= 1'b0;
            ready_q     <= 1'b0;
            state       <= SELECT;
          end
        end
        SELECT: begin
          if (remaining_q == '0) begin
            done_q <= 1'b1;
            state  <= FINISH;
          end else if (sel_coin == COIN_NONE) begin
            // Something is still owed but no stocked coin fits: exact change impossible.
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= FINISH;
          end else begin
            coin_q  <= sel_coin;
            valid_q <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (valid_q && bus.coin_ack) begin
            // Selector guarantees coin <= remaining and the matching stock is non-zero.
            remaining_q <= remaining_q - AMT_W'(coin_q);
            case (coin_q)
              COIN_10: if (stk10 != '0) stk10 <= stk10 - CNT_W'(1);
              COIN_5:  if (stk5 != '0)  stk5  <= stk5 - CNT_W'(1);
              COIN_1:  if (stk1 != '0)  stk1  <= stk1 - CNT_W'(1);
              default: ;
            endcase
            valid_q <= 1'b0;
            coin_q  <= COIN_NONE;
            state   <= SELECT;
          end
        end
        FINISH: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: scoreboard of expected coins from a greedy stock model.
// Latency: n/a.
// Backpressure: bench drives coin_ack with configurable hold-off.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int AMT_W      = 8;
  localparam int CNT_W      = 6;
  localparam int INIT_STOCK = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_STOCK(INIT_STOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  coin_t exp_q[$];
  int    m10, m5, m1;

  // Greedy reference: pushes the expected coin sequence, updates model stock.
  function automatic void model_load(input int amt, output int rem, output bit err);
    rem = amt;
    err = 1'b0;
    while (rem > 0) begin
      if (rem >= 10 && m10 > 0) begin
        exp_q.push_back(4'd10); rem -= 10; m10--;
      end else if (rem >= 5 && m5 > 0) begin
        exp_q.push_back(4'd5); rem -= 5; m5--;
      end else if (m1 > 0) begin
        exp_q.push_back(4'd1); rem -= 1; m1--;
      end else begin
        err = 1'b1;
        break;
      end
    end
  endfunction

  // Runs one transaction; hold = ack hold-off cycles per coin; disturb pulses start/refill mid-OFFER
  // and toggles coin_ack while no coin is offered.
  task automatic pay(input int amt, input int hold, input bit with_refill, input bit disturb, input string tag);
    int    exp_rem;
    bit    exp_err;
    int    cyc;
    int    held;
    bit    seen_done;
    coin_t cur;
    coin_t e;
    if (with_refill) begin
      m10 = INIT_STOCK; m5 = INIT_STOCK; m1 = INIT_STOCK;
    end
    model_load(amt, exp_rem, exp_err);
    @(negedge clk);
    bus.start = 1'b1;
    bus.refill = with_refill;
    bus.change_amount = AMT_W'(amt);
    bus.coin_ack = 1'b0;
    @(negedge clk);
    cyc = 0; held = 0; seen_done = 1'b0; cur = COIN_NONE;
    while (!seen_done && cyc < 3000) begin
      bus.start = 1'b0;
      bus.refill = 1'b0;
      if (cyc == 0) begin
        n_checks++;
        if (bus.error !== 1'b0 || bus.ready !== 1'b0 || bus.coin_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s accept: error=%b ready=%b coin_valid=%b, required 0/0/0", tag, bus.error, bus.ready, bus.coin_valid);
        end
      end
      if (cyc == 1) begin
        n_checks++;
        if (bus.coin_valid !== 1'b1 && bus.done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s latency: no coin_valid/done 2 cycles after start", tag);
        end
      end
      if (bus.coin_valid === 1'b1) begin
        if (held == 0) begin
          cur = bus.coin_out;
        end else begin
          n_checks++;
          if (bus.coin_out !== cur) begin
            n_fail++;
            $display("FAIL %s stable: coin_out=%0d, required %0d", tag, bus.coin_out, cur);
          end
        end
        if (held >= hold) begin
          bus.coin_ack = 1'b1;
          held = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s extra coin: got %0d, required none", tag, cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL %s coin: got %0d, required %0d", tag, cur, e);
            end
          end
        end else begin
          bus.coin_ack = 1'b0;
          held++;
          if (disturb && held == 1) begin
            bus.start = 1'b1;
            bus.change_amount = AMT_W'(99);
            bus.refill = 1'b1;
          end
        end
      end else begin
        n_checks++;
        if (bus.coin_out !== COIN_NONE) begin
          n_fail++;
          $display("FAIL %s idle coin_out: got %0d, required 0", tag, bus.coin_out);
        end
        bus.coin_ack = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
        if (bus.done === 1'b1) begin
          seen_done = 1'b1;
          n_checks++;
          if (bus.error !== exp_err || bus.remaining !== AMT_W'(exp_rem) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s done: error=%b remaining=%0d coins_left=%0d, required error=%b remaining=%0d coins_left=0",
                     tag, bus.error, bus.remaining, exp_q.size(), exp_err, exp_rem);
          end
          n_checks++;
          if (dut.stk10 !== CNT_W'(m10) || dut.stk5 !== CNT_W'(m5) || dut.stk1 !== CNT_W'(m1)) begin
            n_fail++;
            $display("FAIL %s stock: got %0d/%0d/%0d, required %0d/%0d/%0d",
                     tag, dut.stk10, dut.stk5, dut.stk1, m10, m5, m1);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.coin_ack = 1'b0;
    bus.start = 1'b0;
    bus.refill = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s timeout: done never seen, required done", tag);
      exp_q.delete();
    end else if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.error !== exp_err) begin
      n_fail++;
      $display("FAIL %s after done: done=%b ready=%b error=%b, required 0/1/%b", tag, bus.done, bus.ready, bus.error, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.refill = 1'b0; bus.coin_ack = 1'b0; bus.change_amount = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.coin_valid !== 1'b0 || bus.coin_out !== COIN_NONE ||
        bus.done !== 1'b0 || bus.error !== 1'b0 || bus.remaining !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: ready=%b vld=%b coin=%0d done=%b err=%b rem=%0d, required 1/0/0/0/0/0",
               bus.ready, bus.coin_valid, bus.coin_out, bus.done, bus.error, bus.remaining);
    end
    n_checks++;
    if (dut.stk10 !== CNT_W'(INIT_STOCK) || dut.stk5 !== CNT_W'(INIT_STOCK) || dut.stk1 !== CNT_W'(INIT_STOCK)) begin
      n_fail++;
      $display("FAIL reset stock: got %0d/%0d/%0d, required %0d each", dut.stk10, dut.stk5, dut.stk1, INIT_STOCK);
    end
    rst = 1'b0;
    m10 = INIT_STOCK; m5 = INIT_STOCK; m1 = INIT_STOCK;
    exp_q.delete();
  endtask

  task automatic test_basic();
    pay(17, 0, 1'b0, 1'b0, "basic17");
  endtask

  task automatic test_zero();
    pay(0, 0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_backpressure();
    pay(5, 6, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_exhaustion();
    pay(200, 0, 1'b1, 1'b0, "drain10");
    pay(20, 0, 1'b0, 1'b0, "fives");
    for (int i = 0; i < 5; i++) pay(4, 0, 1'b0, 1'b0, "drain1");
    pay(3, 0, 1'b0, 1'b0, "no_change");
  endtask

  task automatic test_busy_ignore();
    pay(40, 2, 1'b1, 1'b1, "busy40");
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.change_amount = AMT_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.coin_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.coin_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid offer: coin_valid=%b, required 1", bus.coin_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.coin_valid !== 1'b0 || bus.ready !== 1'b1 || bus.remaining !== '0 || bus.coin_out !== COIN_NONE) begin
      n_fail++;
      $display("FAIL reset_mid outputs: vld=%b ready=%b rem=%0d coin=%0d, required 0/1/0/0",
               bus.coin_valid, bus.ready, bus.remaining, bus.coin_out);
    end
    n_checks++;
    if (dut.stk10 !== CNT_W'(INIT_STOCK) || dut.stk5 !== CNT_W'(INIT_STOCK) || dut.stk1 !== CNT_W'(INIT_STOCK)) begin
      n_fail++;
      $display("FAIL reset_mid stock: got %0d/%0d/%0d, required %0d each", dut.stk10, dut.stk5, dut.stk1, INIT_STOCK);
    end
    rst = 1'b0;
    m10 = INIT_STOCK; m5 = INIT_STOCK; m1 = INIT_STOCK;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      pay(int'($urandom_range(0, 60)), int'($urandom_range(0, 2)), 1'b0, 1'b0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_exhaustion();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
